// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
//   Return-address stack for branch prediction. Calls push the link address,
//   returns pop it, and the current top is offered to fetch as the predicted
//   return target. The stack is circular, so an overflow discards the oldest
//   entry and keeps the newest DEPTH entries.
//
// Parameters
//   N          address/data width in bits
//   DEPTH      number of entries (power of 2, >= 2)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset; clears all state
//   flush      synchronous clear of pointer/count/flags (entries untouched)
//   push       call detected; store push_addr on this edge
//   push_addr  link address to push
//   pop        return detected; consume top entry on this edge
//   top_addr   predicted return address (0 when empty)
//   top_valid  stack non-empty
//   full       count == DEPTH
//   count      number of valid entries
//   overflow   sticky: push while full
//   underflow  sticky: pop while empty
//
// Optional feature (macro RAS_BYPASS_EN)
//   When defined, an in-flight push (push=1, flush=0) is forwarded to
//   top_addr/top_valid combinationally in the same cycle.
// -----------------------------------------------------------------------------
module return_addr_stack #(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [N-1:0]             push_addr,
    input  logic                     pop,
    output logic [N-1:0]             top_addr,
    output logic                     top_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;

    assign ptr_inc = ptr_q + 1'b1;
    assign ptr_dec = ptr_q - 1'b1;

    // Next-state: flush > push&pop (non-empty) > push > pop > hold.
    // push&pop on an empty stack falls through to the push branch.
    always_comb begin
        mem_d       = mem_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            ptr_d       = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (push && pop && (count_q != '0)) begin
            mem_d[ptr_q] = push_addr;
        end else if (push) begin
            ptr_d          = ptr_inc;
            mem_d[ptr_inc] = push_addr;
            if (count_q == COUNT_MAX) begin
                // Pointer wrap lands on the oldest entry, overwriting it.
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            if (count_q != '0) begin
                ptr_d   = ptr_dec;
                count_d = count_q - 1'b1;
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        top_valid = (count_q != '0);
        top_addr  = (count_q != '0) ? mem_q[ptr_q] : '0;
`ifdef RAS_BYPASS_EN
        if (push && !flush) begin
            top_valid = 1'b1;
            top_addr  = push_addr;
        end
`endif
    end

    assign full      = (count_q == COUNT_MAX);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// -----------------------------------------------------------------------------
// tb_return_addr_stack
//   Directed testbench for return_addr_stack (N=32, DEPTH=8). Inputs change
//   1 time unit after the rising edge; outputs are checked before the next
//   edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_return_addr_stack;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        push;
    logic [31:0] push_addr;
    logic        pop;
    logic [31:0] top_addr;
    logic        top_valid;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    return_addr_stack #(.N(32), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .top_addr  (top_addr),
        .top_valid (top_valid),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        flush = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0;
    endtask

    task automatic do_push(input logic [31:0] a);
        push = 1'b1; push_addr = a;
        tick();
        idle();
    endtask

    task automatic do_pop;
        pop = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();
        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_top", top_addr, 32'h0);
        chk("rst_valid", 32'(top_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);
        reset = 1'b1;
        tick();

        // Basic LIFO
        do_push(32'h100);
        chk("p1_top", top_addr, 32'h100);
        do_push(32'h200);
        do_push(32'h300);
        chk("p3_count", 32'(count), 32'd3);
        chk("p3_top", top_addr, 32'h300);
        chk("p3_valid", 32'(top_valid), 32'd1);
        do_pop();
        chk("pop1_top", top_addr, 32'h200);
        do_pop();
        chk("pop2_top", top_addr, 32'h100);
        do_pop();
        chk("pop3_top", top_addr, 32'h0);
        chk("pop3_valid", 32'(top_valid), 32'd0);
        chk("pop3_count", 32'(count), 32'd0);
        chk("pop3_udf", 32'(underflow), 32'd0);

        // Overflow and wrap-around
        for (int i = 1; i <= 8; i++) do_push(32'(i * 16));
        chk("ovf8_full", 32'(full), 32'd1);
        chk("ovf8_flag", 32'(overflow), 32'd0);
        do_push(32'h90);
        chk("ovf9_full", 32'(full), 32'd1);
        chk("ovf9_count", 32'(count), 32'd8);
        chk("ovf9_flag", 32'(overflow), 32'd1);
        chk("ovf9_top", top_addr, 32'h90);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("wrap_top%0d", k), top_addr, 32'(32'h90 - 16 * k));
            do_pop();
        end
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_valid", 32'(top_valid), 32'd0);
        chk("wrap_udf0", 32'(underflow), 32'd0);
        chk("wrap_ovf_sticky", 32'(overflow), 32'd1);
        do_pop();
        chk("wrap_udf1", 32'(underflow), 32'd1);
        chk("wrap_count_udf", 32'(count), 32'd0);
        chk("wrap_top_udf", top_addr, 32'h0);
        flush = 1'b1;
        tick();
        idle();
        chk("flush_ovf", 32'(overflow), 32'd0);
        chk("flush_udf", 32'(underflow), 32'd0);

        // Push+pop replace with count==1
        do_push(32'h400);
        push = 1'b1; pop = 1'b1; push_addr = 32'h500;
        tick();
        idle();
        chk("swap1_count", 32'(count), 32'd1);
        chk("swap1_top", top_addr, 32'h500);
        do_pop();
        chk("swap1_pop_valid", 32'(top_valid), 32'd0);

        // Push+pop replace with count==2
        do_push(32'h600);
        do_push(32'h700);
        push = 1'b1; pop = 1'b1; push_addr = 32'h800;
        tick();
        idle();
        chk("swap2_count", 32'(count), 32'd2);
        chk("swap2_top", top_addr, 32'h800);
        do_pop();
        chk("swap2_pop_top", top_addr, 32'h600);
        do_pop();

        // Push+pop on empty acts as push, no underflow
        push = 1'b1; pop = 1'b1; push_addr = 32'h903;
        tick();
        idle();
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_top", top_addr, 32'h903);
        chk("pp_empty_udf", 32'(underflow), 32'd0);
        do_pop();

        // Pop on empty, then flush overriding push
        do_pop();
        chk("empty_pop_udf", 32'(underflow), 32'd1);
        chk("empty_pop_count", 32'(count), 32'd0);
        chk("empty_pop_top", top_addr, 32'h0);
        flush = 1'b1; push = 1'b1; push_addr = 32'hDEAD;
        tick();
        idle();
        chk("flushpush_count", 32'(count), 32'd0);
        chk("flushpush_udf", 32'(underflow), 32'd0);
        chk("flushpush_valid", 32'(top_valid), 32'd0);

        // Same-cycle visibility of an in-flight push
        push = 1'b1; push_addr = 32'hC0;
        #1;
`ifdef RAS_BYPASS_EN
        chk("byp_top", top_addr, 32'hC0);
        chk("byp_valid", 32'(top_valid), 32'd1);
`else
        chk("nobyp_top", top_addr, 32'h0);
        chk("nobyp_valid", 32'(top_valid), 32'd0);
`endif
        tick();
        idle();
        chk("byp_after_top", top_addr, 32'hC0);
        chk("byp_after_count", 32'(count), 32'd1);
        do_pop();

        // Asynchronous reset mid-cycle with pop pending
        do_push(32'hA0);
        do_push(32'hB0);
        chk("arst_pre_top", top_addr, 32'hB0);
        pop = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_top", top_addr, 32'h0);
        chk("arst_valid", 32'(top_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        chk("arst_rel_count", 32'(count), 32'd0);
        chk("arst_rel_valid", 32'(top_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
